// File: rtl/alu_logic_result_stage.sv
// Result stage behind the ALU XOR/XNOR units: selects the per-op result, derives
// zero/parity/popcount flags and buffers everything in a small first-word-fall-through FIFO.
module alu_logic_result_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         op_sel,
  input  logic [WIDTH-1:0]             xor_in,
  input  logic [WIDTH-1:0]             xnor_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_zero,
  output logic                         out_parity,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err,
  input  logic                         err_clr
);

  localparam int unsigned ONES_W = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  data_mem   [DEPTH];
  logic              zero_mem   [DEPTH];
  logic              parity_mem [DEPTH];
  logic [ONES_W-1:0] ones_mem   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  logic [WIDTH-1:0]  sel_data;
  logic              sel_zero;
  logic              sel_parity;
  logic [ONES_W-1:0] sel_ones;
  logic              push;
  logic              pop;

  // Flags are derived once at push time and travel with the entry.
  always_comb begin
    sel_data = op_sel ? xnor_in : xor_in;
    sel_ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sel_ones = sel_ones + ONES_W'(sel_data[i]);
    end
    sel_parity = ^sel_data;
    sel_zero   = (sel_ones == '0);
  end

  // Ready depends on occupancy only, so a full buffer refuses a push even during a pop.
  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    out_data   = '0;
    out_zero   = 1'b0;
    out_parity = 1'b0;
    out_ones   = '0;
    if (out_valid) begin
      out_data   = data_mem[rd_ptr];
      out_zero   = zero_mem[rd_ptr];
      out_parity = parity_mem[rd_ptr];
      out_ones   = ones_mem[rd_ptr];
    end
  end

  always_comb begin
    count        = count_q;
    overflow_err = err_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]   <= sel_data;
      zero_mem[wr_ptr]   <= sel_zero;
      parity_mem[wr_ptr] <= sel_parity;
      ones_mem[wr_ptr]   <= sel_ones;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // A new violation takes priority over a clear issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

endmodule
